branch_queue: RTL and testbench

In-order queue of in-flight control-flow instructions, the slave end of the `bq_push_if` branch-queue push protocol. Decode pushes one branch per cycle and receives its queue index (`bqid`) in the same cycle. The branch unit later resolves entries out of order. The queue detects mispredictions, raises the pipeline squash as `squash_if` master, and frees entries in program order on commit.

---
 rtl/branch_queue_if.sv | 31 +++
 rtl/branch_queue.sv | 141 ++++++++++++++
 tb/tb_branch_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_queue_if.sv
// Decode-to-branch-queue push interface and pipeline squash interface.
// The bp struct places taken above pcnext, so it packs as {taken, pcnext}.
interface bq_push_if #(
  parameter int unsigned BQID_W = 3
);
  typedef logic [7:0] id_t;
  typedef struct packed {
    logic        taken;
    logic [63:0] pcnext;
  } bp_t;

  logic              valid;
  logic [63:0]       pc;
  id_t               id;
  bp_t               bp;
  logic [BQID_W-1:0] bqid;

  modport master (output valid, pc, id, bp, input bqid);
  modport slave  (input valid, pc, id, bp, output bqid);
endinterface

interface squash_if;
  typedef logic [7:0] id_t;

  logic        valid;
  id_t         id;
  logic [63:0] pc;

  modport master (output valid, id, pc);
  modport slave  (input valid, id, pc);
endinterface

// File: rtl/branch_queue.sv
// In-order queue of in-flight branches: push at tail, out-of-order resolve,
// misprediction squash with truncation, in-order commit at head.
module branch_queue #(
  parameter int unsigned NR_ENTRIES = 8,
  localparam int unsigned BQID_W = $clog2(NR_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  bq_push_if.slave          bq_push_io,
  output logic              full_o,
  output logic              empty_o,
  input  logic              res_valid_i,
  input  logic [BQID_W-1:0] res_bqid_i,
  input  logic              res_taken_i,
  input  logic [63:0]       res_target_i,
  input  logic              commit_valid_i,
  squash_if.master          squash_io
);
  localparam int unsigned PtrW = BQID_W + 1;
  typedef logic [BQID_W-1:0] idx_t;
  typedef logic [PtrW-1:0]   ptr_t;

  logic [NR_ENTRIES-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic [NR_ENTRIES-1:0] bp_taken_q;
  logic [63:0]           pc_q        [NR_ENTRIES];
  logic [7:0]            id_q        [NR_ENTRIES];
  logic [63:0]           bp_pcnext_q [NR_ENTRIES];

  ptr_t head_q, head_d, tail_q, tail_d, count;
  idx_t head_idx, tail_idx, res_age;
  idx_t age [NR_ENTRIES];

  logic        squash_valid_q;
  logic [7:0]  squash_id_q;
  logic [63:0] squash_pc_q;

  logic        commit_ok, commit_fire, res_ok, mispredict, push_fire;
  logic [63:0] redirect;

  assign head_idx = head_q[BQID_W-1:0];
  assign tail_idx = tail_q[BQID_W-1:0];
  assign count    = tail_q - head_q;
  assign full_o   = (count == ptr_t'(NR_ENTRIES));
  assign empty_o  = (count == '0);

  assign bq_push_io.bqid = tail_idx;
  assign squash_io.valid = squash_valid_q;
  assign squash_io.id    = squash_id_q;
  assign squash_io.pc    = squash_pc_q;

  // Age of each slot relative to the oldest entry; larger means younger.
  always_comb begin
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      age[i] = idx_t'(i) - head_idx;
    end
  end
  assign res_age = res_bqid_i - head_idx;

  assign commit_ok   = !empty_o && valid_q[head_idx] && resolved_q[head_idx];
  assign commit_fire = commit_valid_i && commit_ok;
  // A head being committed is already resolved, so a resolve aimed at it is dropped.
  assign res_ok      = res_valid_i && valid_q[res_bqid_i] &&
                       !(commit_valid_i && (res_bqid_i == head_idx));
  assign mispredict  = res_ok && ((res_taken_i != bp_taken_q[res_bqid_i]) ||
                       (res_taken_i && (res_target_i != bp_pcnext_q[res_bqid_i])));
  assign redirect    = res_taken_i ? res_target_i : (pc_q[res_bqid_i] + 64'd4);
  // A commit in the same cycle frees the head slot, which is the tail slot when full.
  assign push_fire   = bq_push_io.valid && (!full_o || commit_fire) &&
                       !squash_valid_q && !mispredict;

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (res_ok) begin
      resolved_d[res_bqid_i] = 1'b1;
    end
    if (commit_fire) begin
      valid_d[head_idx]    = 1'b0;
      resolved_d[head_idx] = 1'b0;
      head_d               = head_q + ptr_t'(1);
    end
    if (mispredict) begin
      tail_d = head_q + ptr_t'(res_age) + ptr_t'(1);
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        if (age[i] > res_age) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
    end else if (push_fire) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      resolved_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      squash_valid_q <= 1'b0;
      squash_id_q    <= '0;
      squash_pc_q    <= '0;
    end else begin
      valid_q        <= valid_d;
      resolved_q     <= resolved_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      squash_valid_q <= mispredict;
      if (mispredict) begin
        squash_id_q <= id_q[res_bqid_i];
        squash_pc_q <= redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_q[tail_idx]        <= bq_push_io.pc;
      id_q[tail_idx]        <= bq_push_io.id;
      bp_taken_q[tail_idx]  <= bq_push_io.bp.taken;
      bp_pcnext_q[tail_idx] <= bq_push_io.bp.pcnext;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bq_push_io.valid && full_o && !commit_fire))
        else $warning("branch_queue: push while full dropped");
      assert (!commit_valid_i || commit_ok)
        else $warning("branch_queue: commit of empty or unresolved head ignored");
    end
  end
`endif

endmodule

// File: tb/tb_branch_queue.sv
// Directed and randomized bench for branch_queue against a queue-based
// reference model of in-flight branches.
module tb_branch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        full, empty;
  logic        res_valid, res_taken, commit_valid;
  logic [2:0]  res_bqid;
  logic [63:0] res_target;

  always #5 clk = ~clk;

  bq_push_if #(.BQID_W(3)) bq ();
  squash_if sq ();

  branch_queue #(.NR_ENTRIES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bq_push_io     (bq),
    .full_o         (full),
    .empty_o        (empty),
    .res_valid_i    (res_valid),
    .res_bqid_i     (res_bqid),
    .res_taken_i    (res_taken),
    .res_target_i   (res_target),
    .commit_valid_i (commit_valid),
    .squash_io      (sq)
  );

  typedef struct {
    logic [63:0] pc;
    logic [7:0]  id;
    bit          taken;
    logic [63:0] pcnext;
    bit          resolved;
  } ent_t;

  ent_t        mq[$];
  int          head_cnt = 0;
  bit          m_sq_valid = 1'b0;
  logic [7:0]  m_sq_id = '0;
  logic [63:0] m_sq_pc = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bq.valid = 1'b0; bq.pc = '0; bq.id = '0; bq.bp = '0;
    res_valid = 1'b0; res_bqid = '0; res_taken = 1'b0; res_target = '0;
    commit_valid = 1'b0;
  endtask

  task automatic check_outputs();
    check("bqid", 64'(bq.bqid), 64'((head_cnt + mq.size()) % 8));
    check("full", 64'(full), 64'(mq.size() == 8));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("squash_valid", 64'(sq.valid), 64'(m_sq_valid));
    if (m_sq_valid) begin
      check("squash_id", 64'(sq.id), 64'(m_sq_id));
      check("squash_pc", sq.pc, m_sq_pc);
    end
  endtask

  // One clock cycle: drive, check current outputs, advance model, cross the edge.
  task automatic step(input bit push, input logic [63:0] pc, input logic [7:0] id,
                      input bit bt, input logic [63:0] bpn, input bit res, input int rb,
                      input bit rt, input logic [63:0] rtg, input bit cm);
    int   k;
    bit   rok, mis, cok, pok;
    ent_t e;
    bq.valid = push; bq.pc = pc; bq.id = id; bq.bp = {bt, bpn};
    res_valid = res; res_bqid = 3'(rb); res_taken = rt; res_target = rtg;
    commit_valid = cm;
    #1;
    check_outputs();
    k   = (rb - head_cnt) & 7;
    rok = res && (k < mq.size()) && !(cm && k == 0);
    mis = rok && ((rt != mq[k].taken) || (rt && rtg != mq[k].pcnext));
    cok = cm && (mq.size() > 0) && mq[0].resolved;
    pok = push && ((mq.size() < 8) || cok) && !m_sq_valid && !mis;
    m_sq_valid = mis;
    if (mis) begin
      m_sq_id = mq[k].id;
      m_sq_pc = rt ? rtg : mq[k].pc + 64'd4;
    end
    if (rok) mq[k].resolved = 1'b1;
    if (mis) while (mq.size() > k + 1) void'(mq.pop_back());
    if (cok) begin
      void'(mq.pop_front());
      head_cnt++;
    end
    if (pok) begin
      e.pc = pc; e.id = id; e.taken = bt; e.pcnext = bpn; e.resolved = 1'b0;
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic push_step(input logic [63:0] pc, input logic [7:0] id, input bit bt,
                           input logic [63:0] bpn);
    step(1'b1, pc, id, bt, bpn, 1'b0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic res_step(input int rb, input bit rt, input logic [63:0] rtg);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, rb, rt, rtg, 1'b0);
  endtask

  task automatic commit_step();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_bqid", 64'(bq.bqid), 64'd0);
    check("rst_sq_valid", 64'(sq.valid), 64'd0);
    check("rst_sq_id", 64'(sq.id), 64'd0);
    check("rst_sq_pc", sq.pc, 64'd0);
    mq.delete();
    head_cnt   = 0;
    m_sq_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          p, r, c, rt, bt;
    int          rb, k;
    logic [63:0] pc, pn, tg;
    drive_idle();
    @(negedge clk);
    do_reset();

    // Single branch: push, correct resolve, commit.
    push_step(64'h8000_0000, 8'd3, 1'b0, 64'h0);
    res_step(0, 1'b0, '0);
    commit_step();
    idle_step();

    // Fill, overflow push, commit plus push on a full queue, drain.
    do_reset();
    for (int i = 0; i < 8; i++) push_step(64'h1000 + 64'(i * 16), 8'(10 + i), 1'b0, '0);
    push_step(64'h9000, 8'd99, 1'b0, '0);
    res_step(0, 1'b0, '0);
    step(1'b1, 64'h2000, 8'd20, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1);
    for (int i = 1; i < 9; i++) res_step(i % 8, 1'b0, '0);
    for (int i = 0; i < 9; i++) commit_step();

    // Taken-target mismatch truncates to bqid 2.
    do_reset();
    for (int i = 0; i < 5; i++)
      push_step(64'h4000 + 64'(i * 4), 8'(30 + i), i == 2, (i == 2) ? 64'h1000 : 64'h0);
    res_step(2, 1'b1, 64'h2000);
    idle_step();
    idle_step();

    // Not-taken redirect wraps past the top of the address space.
    do_reset();
    push_step(64'hFFFF_FFFF_FFFF_FFFC, 8'd7, 1'b1, 64'h40);
    res_step(0, 1'b0, '0);
    idle_step();

    // Resolve in the squash cycle: invalidated entry ignored.
    do_reset();
    for (int i = 0; i < 5; i++) push_step(64'h5000 + 64'(i * 4), 8'(40 + i), 1'b0, '0);
    res_step(1, 1'b1, 64'h500);
    res_step(3, 1'b1, 64'h700);
    idle_step();

    // Resolve in the squash cycle: older entry squashes again.
    do_reset();
    for (int i = 0; i < 5; i++) push_step(64'h6000 + 64'(i * 4), 8'(50 + i), 1'b0, '0);
    res_step(1, 1'b1, 64'h500);
    res_step(0, 1'b1, 64'h600);
    idle_step();

    // Pointer wrap over 20 push/resolve/commit rounds.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_step(64'h7000 + 64'(i * 4), 8'(60 + i), 1'b0, '0);
      res_step(i % 8, 1'b0, '0);
      commit_step();
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      p  = 1'($urandom_range(0, 1));
      pc = {$urandom, $urandom} & ~64'h3;
      bt = 1'($urandom_range(0, 1));
      pn = 64'($urandom_range(0, 15)) << 2;
      r = 1'b0; rb = 0; rt = 1'b0; tg = '0;
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        k  = int'($urandom_range(0, mq.size() - 1));
        r  = 1'b1;
        rb = (head_cnt + k) % 8;
        if ($urandom_range(0, 3) != 0) begin
          rt = mq[k].taken;
          tg = mq[k].pcnext;
        end else begin
          rt = 1'($urandom_range(0, 1));
          tg = 64'($urandom_range(0, 15)) << 2;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        r  = 1'b1;
        rb = int'($urandom_range(0, 7));
        rt = 1'($urandom_range(0, 1));
      end
      c = (mq.size() > 0) && mq[0].resolved && ($urandom_range(0, 1) == 1);
      step(p, pc, 8'(n), bt, pn, r, rb, rt, tg, c);
    end

    // Asynchronous reset while a squash is pending.
    do_reset();
    push_step(64'h8800, 8'd77, 1'b0, '0);
    push_step(64'h8804, 8'd78, 1'b0, '0);
    res_step(0, 1'b1, 64'h777);
    check_outputs();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_empty", 64'(empty), 64'd1);
    check("async_rst_sq_valid", 64'(sq.valid), 64'd0);
    check("async_rst_bqid", 64'(bq.bqid), 64'd0);
    mq.delete();
    head_cnt   = 0;
    m_sq_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
